ifu_fetch_responder: RTL and testbench
======================================

Name: ifu_fetch_responder

Overview:
- Memory-side responder for the instruction fetch unit.
- Accepts one fetch request at a time as a PC, performs alignment and range checks, and reads a 64-bit instruction SRAM with programmable wait states.
- Returns the selected 32-bit instruction, its PC and an error code via a valid/ready response.
- Supports pipeline flush (branch taken or exception) that drops the in-flight fetch.

Parameters:
- BASE_ADDR, 64'h80000000, byte address of the first SRAM byte; matches the core reset PC.
- MEM_BYTES, 65536, SRAM size in bytes; power of two, at least 8.
- WAIT_CYCLES, 1, extra wait cycles before the SRAM read; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  64  fetch PC (byte address).
- flush  in  1  drop the in-flight fetch (branch taken or exception).
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_inst  out  32  fetched instruction.
- resp_pc  out  64  PC of the response.
- resp_err  out  2  response status: 00 ok, 01 misaligned, 10 access fault.
- sram_en  out  1  SRAM read strobe.
- sram_addr  out  AW  8-byte-aligned byte offset into the SRAM; AW = $clog2(MEM_BYTES).
- sram_rdata  in  64  SRAM read data; valid the cycle after sram_en.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - resp_valid=0, resp_inst=0, resp_pc=0, resp_err=0, sram_en=0, sram_addr=0, wait counter=0.
- req_ready = (state==IDLE) && !flush. This is combinational.
- States: IDLE, WAIT, RD, CAP, RESP.
- IDLE:
  - A request is accepted on req_valid && req_ready. Latch req_addr into an internal PC register.
  - If req_addr[1:0] != 0: go to RESP with err=01, inst=32'h00000013.
  - Otherwise, offset = req_addr - BASE_ADDR, computed as unsigned 64-bit with wrap. If offset >= MEM_BYTES: go to RESP with err=10, inst=32'h00000013.
  - Misaligned takes priority over access fault.
  - Otherwise: load the counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES > 0, else to RD.
- WAIT: decrement the counter each cycle; go to RD when it reaches 1.
- RD:
  - sram_en=1 for exactly one cycle.
  - sram_addr = offset[AW-1:0] with the low 3 bits cleared.
  - Next state CAP.
- CAP:
  - Register resp_inst = pc[2] ? sram_rdata[63:32] : sram_rdata[31:0], resp_err=00.
  - Go to RESP.
- RESP:
  - resp_valid=1. resp_inst, resp_pc and resp_err are held stable until resp_valid && resp_ready.
  - On that handshake, resp_valid drops and the next state is IDLE.
  - No request overlap: req_ready=0 outside IDLE.
- Latency from accept edge to resp_valid high:
  - Good access: WAIT_CYCLES+3 cycles.
  - Error: 1 cycle.
- flush:
  - In WAIT, RD or CAP: go to IDLE next edge; no response is produced. An SRAM read already issued is harmless and its rdata is ignored.
  - In RESP: resp_valid drops next edge and the state returns to IDLE.
  - Same cycle as a RESP handshake: the handshake completes and the state returns to IDLE.
  - In IDLE: blocks acceptance for that cycle.
- resp_pc always equals the accepted req_addr, including for error responses.
- The sram_en strobe is 0 in every state except RD.

Optional Feature:
- Macro: IFU_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[63:0] and perf_stall_cnt[63:0], both reset to 0 asynchronously.
  - perf_fetch_cnt increments on every completed response handshake, error responses included.
  - perf_stall_cnt increments on every cycle with resp_valid && !resp_ready.
  - Both counters wrap at 2^64.
- Undefined: the two ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Good fetches (WAIT_CYCLES=1, sram_rdata=64'hDEADBEEF_00100093):
  - req_addr=64'h80000000 → sram_en at accept+2, sram_addr=0; resp_valid at accept+4 with resp_inst=32'h00100093, resp_pc=64'h80000000, resp_err=00.
  - req_addr=64'h80000004 → resp_inst=32'hDEADBEEF.
- Errors:
  - req_addr=64'h80000002 → resp_valid at accept+1, resp_err=01, resp_inst=32'h00000013, sram_en never asserted.
  - req_addr=64'h7FFFFFFC, and separately 64'h80010000 → resp_err=10 for both.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → outputs stable and req_ready=0 throughout; assert resp_ready → resp_valid=0 and req_ready=1 the following cycle.
- Flush:
  - Assert flush one cycle after accept (in WAIT) → state IDLE next cycle, resp_valid never asserts.
  - The next request at 64'h80000008 returns the word from rdata[31:0] of its own read.
- Async reset: deassert rst_n mid-WAIT and mid-RESP → resp_valid and sram_en go 0 immediately without a clock edge; after release req_ready=1.
- With IFU_FETCH_PERF_EN: 3 handshakes plus 4 backpressure cycles → perf_fetch_cnt=3, perf_stall_cnt=4.

Source files
------------

// File: rtl/ifu_fetch_responder.sv
// ifu_fetch_responder
// Memory-side responder for the instruction fetch unit. Takes one fetch PC at
// a time, checks alignment and range, reads the 64-bit instruction SRAM after
// WAIT_CYCLES wait states and returns the selected 32-bit word on a
// valid/ready response channel. A flush drops whatever fetch is in flight.
//
// Optional feature: define IFU_FETCH_PERF_EN to add the perf_fetch_cnt and
// perf_stall_cnt performance counters.
module ifu_fetch_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int unsigned MEM_BYTES   = 65536,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [63:0]                    req_addr,
    input  logic                           flush,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_inst,
    output logic [63:0]                    resp_pc,
    output logic [1:0]                     resp_err,
    output logic                           sram_en,
    output logic [$clog2(MEM_BYTES)-1:0]   sram_addr,
    input  logic [63:0]                    sram_rdata
`ifdef IFU_FETCH_PERF_EN
    ,
    output logic [63:0]                    perf_fetch_cnt,
    output logic [63:0]                    perf_stall_cnt
`endif
);

    localparam int          AW        = $clog2(MEM_BYTES);
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [AW-1:0] WORD_MASK = ~AW'(7);

    typedef enum logic [1:0] {
        ERR_OK         = 2'b00,
        ERR_MISALIGNED = 2'b01,
        ERR_FAULT      = 2'b10
    } err_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD,
        S_CAP,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;

    logic [63:0] req_off;
    logic        req_misaligned;
    logic        req_fault;
    logic        accept;
    logic        resp_fire;

    // Offset wraps modulo 2^64, so PCs below BASE_ADDR land far above MEM_BYTES.
    assign req_off        = req_addr - BASE_ADDR;
    assign req_misaligned = (req_addr[1:0] != 2'b00);
    assign req_fault      = (req_off >= 64'(MEM_BYTES));

    // Only one fetch in flight; a flush in IDLE also holds off the next accept.
    assign req_ready = (state == S_IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign resp_fire = resp_valid && resp_ready;

    // Fetch sequencer: all response and SRAM-side outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            resp_valid <= 1'b0;
            resp_inst  <= 32'd0;
            resp_pc    <= 64'd0;
            resp_err   <= ERR_OK;
            sram_en    <= 1'b0;
            sram_addr  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; this
            // default makes sram_en a single-cycle strobe without extra terms.
            sram_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // resp_pc doubles as the internal PC register.
                        resp_pc <= req_addr;
                        if (req_misaligned) begin
                            resp_inst  <= NOP_INST;
                            resp_err   <= ERR_MISALIGNED;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else if (req_fault) begin
                            resp_inst  <= NOP_INST;
                            resp_err   <= ERR_FAULT;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            // Address is set up early and held through RD.
                            sram_addr <= req_off[AW-1:0] & WORD_MASK;
                            wait_cnt  <= WAIT_INIT;
                            if (WAIT_CYCLES > 0) begin
                                state <= S_WAIT;
                            end else begin
                                sram_en <= 1'b1;
                                state   <= S_RD;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (flush) begin
                        wait_cnt <= 4'd0;
                        state    <= S_IDLE;
                    end else if (wait_cnt == 4'd1) begin
                        sram_en <= 1'b1;
                        state   <= S_RD;
                    end
                end
                S_RD: begin
                    // A read already issued is harmless; its data is simply ignored.
                    state <= flush ? S_IDLE : S_CAP;
                end
                S_CAP: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        resp_inst  <= resp_pc[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                        resp_err   <= ERR_OK;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Handshake and flush both retire the response.
                    if (resp_ready || flush) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IFU_FETCH_PERF_EN
    // Performance counters: completed responses and back-pressured cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 64'd0;
            perf_stall_cnt <= 64'd0;
        end else begin
            if (resp_fire) begin
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            end
            if (resp_valid && !resp_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            end
        end
    end
`else
    // Without the counters the handshake strobe has no consumer.
    logic unused_fire;
    assign unused_fire = resp_fire;
`endif

endmodule

// File: tb/tb_ifu_fetch_responder.sv
// tb_ifu_fetch_responder
// Directed bench for ifu_fetch_responder with default parameters
// (BASE_ADDR 0x80000000, 64 KiB, WAIT_CYCLES 1). Define IFU_FETCH_PERF_EN to
// also exercise the performance counters.
module tb_ifu_fetch_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic [63:0] resp_pc;
    logic [1:0]  resp_err;
    logic        sram_en;
    logic [15:0] sram_addr;
    logic [63:0] sram_rdata;
`ifdef IFU_FETCH_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_pc    (resp_pc),
        .resp_err   (resp_err),
        .sram_en    (sram_en),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata)
`ifdef IFU_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM contents: word 0 is {DEADBEEF, 00100093}; other words are tagged by address.
    function automatic logic [63:0] mem_word(input logic [15:0] a);
        return {32'hDEAD_BEEF ^ {16'h0, a}, 32'h0010_0093 ^ {16'h0, a}};
    endfunction

    // SRAM model: data valid only in the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (sram_en) sram_rdata <= mem_word(sram_addr);
        else         sram_rdata <= 64'h0BAD_0BAD_0BAD_0BAD;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch: measures latency and strobe timing, optional back-pressure hold.
    task automatic run_fetch(input string tag, input logic [63:0] addr, input int hold,
                             input int exp_lat, input logic [31:0] exp_inst,
                             input logic [1:0] exp_err, input int exp_en,
                             input logic [15:0] exp_sa);
        int          lat;
        int          en_seen;
        int          en_at;
        logic [15:0] en_addr;
        lat = 0; en_seen = 0; en_at = 0; en_addr = '0;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = addr;
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        do begin
            tick();
            req_valid = 1'b0;
            lat++;
            if (sram_en) begin
                en_seen++;
                en_at   = lat;
                en_addr = sram_addr;
            end
        end while (!resp_valid && lat < 32);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " sram_en count"}, 64'(en_seen), 64'(exp_en));
        check({tag, " sram_en time"}, 64'(en_at), (exp_en > 0) ? 64'(exp_lat - 2) : 64'd0);
        check({tag, " sram_addr"}, 64'(en_addr), 64'(exp_sa));
        check({tag, " resp_inst"}, 64'(resp_inst), 64'(exp_inst));
        check({tag, " resp_pc"}, resp_pc, addr);
        check({tag, " resp_err"}, 64'(resp_err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold valid"}, 64'(resp_valid), 64'd1);
            check({tag, " hold inst"}, 64'(resp_inst), 64'(exp_inst));
            check({tag, " hold pc"}, resp_pc, addr);
            check({tag, " hold err"}, 64'(resp_err), 64'(exp_err));
            check({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, " done valid"}, 64'(resp_valid), 64'd0);
        check({tag, " done req_ready"}, 64'(req_ready), 64'd1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, " async valid"}, 64'(resp_valid), 64'd0);
        check({tag, " async sram_en"}, 64'(sram_en), 64'd0);
        check({tag, " async err"}, 64'(resp_err), 64'd0);
        check({tag, " async pc"}, resp_pc, 64'd0);
        #2 rst_n = 1'b1;
        tick();
        check({tag, " post req_ready"}, 64'(req_ready), 64'd1);
        check({tag, " post valid"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 64'd0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        #1;
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset resp_inst", 64'(resp_inst), 64'd0);
        check("reset resp_pc", resp_pc, 64'd0);
        check("reset resp_err", 64'(resp_err), 64'd0);
        check("reset sram_en", 64'(sram_en), 64'd0);
        check("reset sram_addr", 64'(sram_addr), 64'd0);
        #12 rst_n = 1'b1;
        tick();
        check("reset req_ready", 64'(req_ready), 64'd1);

        // Good fetches, low and high word, plus the last word in range.
        run_fetch("good_lo", 64'h8000_0000, 0, 4, 32'h0010_0093, 2'b00, 1, 16'h0000);
        run_fetch("good_hi", 64'h8000_0004, 0, 4, 32'hDEAD_BEEF, 2'b00, 1, 16'h0000);
        run_fetch("good_top", 64'h8000_FFFC, 0, 4, 32'hDEAD_4117, 2'b00, 1, 16'hFFF8);

        // Error responses: no SRAM access, one-cycle latency.
        run_fetch("misalign", 64'h8000_0002, 0, 1, 32'h0000_0013, 2'b01, 0, 16'h0000);
        run_fetch("below_base", 64'h7FFF_FFFC, 0, 1, 32'h0000_0013, 2'b10, 0, 16'h0000);
        run_fetch("past_end", 64'h8001_0000, 0, 1, 32'h0000_0013, 2'b10, 0, 16'h0000);
        run_fetch("mis_prio", 64'h7FFF_FFFE, 0, 1, 32'h0000_0013, 2'b01, 0, 16'h0000);

        // Back-pressure for five cycles in RESP.
        run_fetch("bp", 64'h8000_0004, 5, 4, 32'hDEAD_BEEF, 2'b00, 1, 16'h0000);

        // Flush while in WAIT: no response; flush in IDLE blocks acceptance.
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        tick();
        req_valid = 1'b0;
        flush     = 1'b1;
        tick();
        check("flush_wait req_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b1;
        req_addr  = 64'h8000_0002;
        tick();
        req_valid = 1'b0;
        check("flush_idle blocked", 64'(resp_valid), 64'd0);
        flush = 1'b0;
        #1;
        check("flush_wait idle", 64'(req_ready), 64'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (resp_valid) seen++;
            end
            check("flush_wait no resp", 64'(seen), 64'd0);
        end
        run_fetch("after_flush", 64'h8000_0008, 0, 4, 32'h0010_009B, 2'b00, 1, 16'h0008);

        // Flush while a response is pending.
        req_valid = 1'b1;
        req_addr  = 64'h8000_0002;
        tick();
        req_valid = 1'b0;
        check("flush_resp valid", 64'(resp_valid), 64'd1);
        flush = 1'b1;
        tick();
        check("flush_resp dropped", 64'(resp_valid), 64'd0);
        flush = 1'b0;
        #1;
        check("flush_resp req_ready", 64'(req_ready), 64'd1);

        // Async reset mid-WAIT, mid-RD (strobe high) and mid-RESP.
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        tick();
        req_valid = 1'b0;
        pulse_reset("rst_wait");
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("rst_rd strobe", 64'(sram_en), 64'd1);
        pulse_reset("rst_rd");
        req_valid = 1'b1;
        req_addr  = 64'h8001_0000;
        tick();
        req_valid = 1'b0;
        check("rst_resp valid", 64'(resp_valid), 64'd1);
        pulse_reset("rst_resp");

`ifdef IFU_FETCH_PERF_EN
        // Counters: three handshakes, four stall cycles.
        pulse_reset("perf");
        run_fetch("perf1", 64'h8000_0000, 4, 4, 32'h0010_0093, 2'b00, 1, 16'h0000);
        run_fetch("perf2", 64'h8000_0004, 0, 4, 32'hDEAD_BEEF, 2'b00, 1, 16'h0000);
        run_fetch("perf3", 64'h8000_0001, 0, 1, 32'h0000_0013, 2'b01, 0, 16'h0000);
        check("perf_fetch_cnt", perf_fetch_cnt, 64'd3);
        check("perf_stall_cnt", perf_stall_cnt, 64'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
